result_disp_scan: RTL and testbench
===================================

RESULT_DISP_SCAN -- requirements
Module: result_disp_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 4: clk cycles per digit slot, legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 res_in  input  4  ALU result nibble from the upstream ALU stage.
REQ-005 res_vld  input  1  single-cycle strobe: res_in is valid and is captured this cycle.
REQ-006 clr  input  1  synchronous clear of the result history.
REQ-007 seg  output  [0:6]  active-high segments; seg[0]=a through seg[6]=g.
REQ-008 an  output  4  active-low one-hot digit enable; an[i]=0 selects digit i.
REQ-009 cnt  output  3  number of valid history entries, 0..4.

Function
REQ-010 The history shall hold four 4-bit digits d0..d3, each with a valid bit v0..v3.
REQ-011 When res_vld=1 and clr=0: d3<=d2, d2<=d1, d1<=d0, d0<=res_in; v shifts the same way and v0<=1.
REQ-012 When clr=1: all d<=0 and all v<=0; clr wins over a simultaneous res_vld.
REQ-013 The prescaler shall count 0..REFRESH_DIV-1 and wrap; on terminal count, the digit index idx (2 bits) shall increment, wrapping 3->0.
REQ-014 REFRESH_DIV=1: idx advances every cycle.
REQ-015 an shall be the active-low one-hot of idx: idx0->1110, idx1->1101, idx2->1011, idx3->0111; exactly one zero at all times.
REQ-016 seg shall be the hex decode of d[idx], driven combinationally from registered state; zero added latency after an idx or history change.
REQ-017 Decode table (seg[0:6]): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-018 cnt shall equal the popcount of v0..v3, saturating at 4 because the oldest entry is discarded on the fifth load.
REQ-019 res_vld coinciding with a prescaler terminal count shall perform both updates in the same cycle; neither is lost.
REQ-020 clr and res_vld shall not disturb the prescaler or idx.

Reset
REQ-021 While rst=1: prescaler=0, idx=0, all d=0, all v=0, an=1110, cnt=0, and seg per REQ-023/REQ-024 for digit 0.
REQ-022 rst asserted mid-scan shall take effect immediately without waiting for a clock edge; scanning shall resume at idx=0 on the first edge after release.

Configuration
REQ-023 With BLANK_UNUSED_EN defined, seg shall be 0000000 whenever v[idx]=0.
REQ-024 Without BLANK_UNUSED_EN, seg shall always show the decode of d[idx], so unused digits display "0".

Structure
REQ-025 Package disp_pkg shall hold the DIGITS=4 constant, the 16 segment-code constants, and the AN_IDLE=4'b1111 constant.
REQ-026 Sub-module hex7seg (combinational, 4-bit in, [0:6] out) shall implement REQ-017; result_disp_scan shall instantiate it once.

Verification
REQ-027 Reset check with REFRESH_DIV=4: hold rst for 3 cycles, then release -> an=1110, cnt=0; seg=0000000 with BLANK_UNUSED_EN, 1111110 without.
REQ-028 Scan rotation: run 16 cycles -> an steps 1110,1101,1011,0111 every 4 cycles, then returns to 1110.
REQ-029 History load: strobe res_vld with 2 then 7 -> cnt=2; at idx0 seg=1110000, at idx1 seg=1101101.
REQ-030 Overflow: load 1,2,3,4,5 -> cnt=4, d0..d3 = 5,4,3,2; value 1 is never displayed.
REQ-031 Clear priority: clr=1 with res_vld=1 and res_in=F -> next cycle cnt=0 and all digits 0; idx continues unchanged.
REQ-032 Async reset mid-scan: assert rst between edges at idx=2 -> an=1110 before the next rising edge.

Source files
------------

// File: rtl/disp_pkg.sv
// disp_pkg: shared constants for the result display scanner.
// Holds the digit count, the 7-segment codes (bit order a..g = [0:6],
// active-high) and the all-digits-off anode pattern.
package disp_pkg;

    localparam int DIGITS = 4;

    localparam logic [0:6] SEG_0 = 7'b1111110;
    localparam logic [0:6] SEG_1 = 7'b0110000;
    localparam logic [0:6] SEG_2 = 7'b1101101;
    localparam logic [0:6] SEG_3 = 7'b1111001;
    localparam logic [0:6] SEG_4 = 7'b0110011;
    localparam logic [0:6] SEG_5 = 7'b1011011;
    localparam logic [0:6] SEG_6 = 7'b1011111;
    localparam logic [0:6] SEG_7 = 7'b1110000;
    localparam logic [0:6] SEG_8 = 7'b1111111;
    localparam logic [0:6] SEG_9 = 7'b1111011;
    localparam logic [0:6] SEG_A = 7'b1110111;
    localparam logic [0:6] SEG_B = 7'b0011111;
    localparam logic [0:6] SEG_C = 7'b1001110;
    localparam logic [0:6] SEG_D = 7'b0111101;
    localparam logic [0:6] SEG_E = 7'b1001111;
    localparam logic [0:6] SEG_F = 7'b1000111;

    localparam logic [0:6] SEG_BLANK = 7'b0000000;

    // Active-low anodes: every digit disabled.
    localparam logic [3:0] AN_IDLE = 4'b1111;

    // Active-low one-hot anode pattern selecting digit idx.
    function automatic logic [3:0] an_onehot(input logic [1:0] idx);
        return AN_IDLE & ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex nibble to 7-segment decoder.
// Output bit order is seg[0]=a .. seg[6]=g, active-high.
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [0:6] seg
);

    // Table lookup of the segment pattern for each hex value.
    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_disp_scan.sv
// result_disp_scan: four-deep ALU result history shown on a multiplexed
// 4-digit 7-segment display.
//
// Input handshake: res_vld is a single-cycle strobe with no back-pressure;
// whenever res_vld=1 on a rising edge, res_in is pushed into the history
// (newest in d0, oldest falls out of d3). clr on the same edge wins and
// empties the history instead. Neither input touches the scan timing.
//
// Optional feature: define BLANK_UNUSED_EN to blank digits whose history
// slot has never been loaded; otherwise such digits show "0".
module result_disp_scan
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] res_in,
    input  logic       res_vld,
    input  logic       clr,
    output logic [0:6] seg,
    output logic [3:0] an,
    output logic [2:0] cnt
);

    localparam logic [15:0] PRESC_LAST = 16'(REFRESH_DIV - 1);

    logic [15:0]             presc;
    logic [1:0]              idx;
    logic [DIGITS-1:0][3:0]  d;
    logic [DIGITS-1:0]       v;
    logic [3:0]              cur_digit;
    logic [0:6]              seg_raw;

    // Scan timing: prescaler wraps at REFRESH_DIV-1 and advances the digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    // Result history: shift in on res_vld, clear wins over a simultaneous load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d <= '0;
            v <= '0;
        end else if (clr) begin
            d <= '0;
            v <= '0;
        end else if (res_vld) begin
            d <= {d[DIGITS-2:0], res_in};
            v <= {v[DIGITS-2:0], 1'b1};
        end
    end

    // Entry count is the number of set valid bits; shifting caps it at DIGITS.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < DIGITS; i++) begin
            cnt = cnt + 3'(v[i]);
        end
    end

    // Digit selection and anode drive follow the registered index directly.
    always_comb begin
        cur_digit = d[idx];
        an        = an_onehot(idx);
    end

    hex7seg u_hex7seg (
        .hex (cur_digit),
        .seg (seg_raw)
    );

    // Final segment drive, optionally blanking never-loaded slots.
    always_comb begin
`ifdef BLANK_UNUSED_EN
        seg = v[idx] ? seg_raw : SEG_BLANK;
`else
        seg = seg_raw;
`endif
    end

endmodule

// File: tb/tb_result_disp_scan.sv
// tb_result_disp_scan: directed test of result_disp_scan with REFRESH_DIV=4
// plus a second instance at REFRESH_DIV=1 for the fastest scan rate.
module tb_result_disp_scan;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] res_in = 4'h0;
    logic       res_vld = 1'b0;
    logic       clr = 1'b0;

    logic [0:6] seg, seg1;
    logic [3:0] an, an1;
    logic [2:0] cnt, cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    // bench-side scan model
    int exp_presc = 0;
    int exp_idx   = 0;
    int exp_idx1  = 0;

    always #5 clk = ~clk;

    result_disp_scan #(.REFRESH_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .res_in  (res_in),
        .res_vld (res_vld),
        .clr     (clr),
        .seg     (seg),
        .an      (an),
        .cnt     (cnt)
    );

    result_disp_scan #(.REFRESH_DIV(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .res_in  (res_in),
        .res_vld (res_vld),
        .clr     (clr),
        .seg     (seg1),
        .an      (an1),
        .cnt     (cnt1)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] an_of(input int i);
        logic [3:0] a;
        a = 4'b1111;
        a[i % 4] = 1'b0;
        return a;
    endfunction

    function automatic logic [6:0] seg_of(input int digit, input bit valid);
        logic [6:0] tbl [16];
        tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
`ifdef BLANK_UNUSED_EN
        if (!valid) return 7'b0000000;
`else
        if (!valid) return tbl[digit];
`endif
        return tbl[digit];
    endfunction

    // ---------------- driver tasks ----------------
    // One clock: update the scan model at the edge, return at the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            exp_presc = 0;
            exp_idx   = 0;
            exp_idx1  = 0;
        end else begin
            if (exp_presc == 3) begin
                exp_presc = 0;
                exp_idx   = (exp_idx + 1) % 4;
            end else begin
                exp_presc++;
            end
            exp_idx1 = (exp_idx1 + 1) % 4;
        end
        @(negedge clk);
    endtask

    // Advance (bounded) until the scan reaches digit target.
    task automatic wait_idx(input int target);
        for (int i = 0; i < 16 && exp_idx != target; i++) step();
        check("wait_idx_an", an, an_of(target));
    endtask

    // ---------------- stimulus ----------------
    int ones;
    int ovf_digit [4];

    initial begin
        // reset held three cycles
        rst = 1'b1;
        repeat (3) step();
        check("rst_an", an, 4'b1110);
        check("rst_cnt", cnt, 3'd0);
        check("rst_seg", seg, seg_of(0, 0));
        check("rst_an_div1", an1, 4'b1110);
        rst = 1'b0;
        check("rel_an", an, 4'b1110);
        check("rel_cnt", cnt, 3'd0);
        check("rel_seg", seg, seg_of(0, 0));

        // scan rotation
        for (int k = 1; k <= 16; k++) begin
            step();
            check("scan_an", an, an_of((k / 4) % 4));
            check("scan_an_div1", an1, an_of(k % 4));
        end

        // history load: 2 then 7
        res_vld = 1'b1; res_in = 4'h2; step();
        res_in = 4'h7; step();
        res_vld = 1'b0; res_in = 4'h0;
        check("load_cnt", cnt, 3'd2);
        check("load_cnt_div1", cnt1, 3'd2);
        check("load_an", an, 4'b1110);
        check("load_seg_idx0", seg, 7'b1110000);
        wait_idx(1);
        check("load_seg_idx1", seg, 7'b1101101);

        // overflow: 1..5, loads cross prescaler terminal counts
        res_vld = 1'b1;
        for (int val = 1; val <= 5; val++) begin
            res_in = 4'(val);
            step();
            check("ovf_an", an, an_of(exp_idx));
        end
        res_vld = 1'b0; res_in = 4'h0;
        check("ovf_cnt", cnt, 3'd4);
        check("ovf_cnt_div1", cnt1, 3'd4);
        ovf_digit = '{5, 4, 3, 2};
        for (int k = 0; k < 4; k++) begin
            wait_idx(k);
            check("ovf_seg", seg, seg_of(ovf_digit[k], 1));
        end
        ones = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (seg == 7'b0110000) ones++;
        end
        check("ovf_never_1", ones, 0);

        // clear beats a simultaneous load of F
        clr = 1'b1; res_vld = 1'b1; res_in = 4'hF;
        step();
        clr = 1'b0; res_vld = 1'b0; res_in = 4'h0;
        check("clr_cnt", cnt, 3'd0);
        check("clr_an_continues", an, an_of(exp_idx));
        check("clr_an_div1", an1, an_of(exp_idx1));
        for (int k = 0; k < 4; k++) begin
            wait_idx(k);
            check("clr_seg", seg, seg_of(0, 0));
        end

        // async reset mid-scan at idx=2
        res_vld = 1'b1; res_in = 4'h9; step();
        res_vld = 1'b0; res_in = 4'h0;
        check("pre_rst_cnt", cnt, 3'd1);
        wait_idx(2);
        check("pre_rst_seg", seg, seg_of(0, 0));
        #2 rst = 1'b1;
        #1;
        check("async_an", an, 4'b1110);
        check("async_cnt", cnt, 3'd0);
        check("async_seg", seg, seg_of(0, 0));
        check("async_an_div1", an1, 4'b1110);
        step();
        step();
        rst = 1'b0;
        step();
        check("resume_an", an, 4'b1110);
        check("resume_an_div1", an1, 4'b1101);
        repeat (3) step();
        check("resume_an_idx1", an, 4'b1101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global time bound
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
